// File: rtl/conv_addr_pkg.sv
// ============================================================================
// conv_addr_pkg : shared state encoding, width helpers and pixel helpers for
//                 the conv window address generator.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package conv_addr_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FULL  = 2'd1;
    localparam state_t ST_SLIDE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Two extra bits: one for the sign, one so STEP-scaled offsets cannot wrap.
    function automatic int coord_w(input int addr_w);
        return addr_w + 2;
    endfunction

    // Ceil-log2, floored at 1 so single-entry counters still have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                r = b + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic in_bounds(input int row, input int col,
                                       input int img_h, input int img_w);
        return (row >= 0) && (row < img_h) && (col >= 0) && (col < img_w);
    endfunction

    function automatic int pix_addr(input int row, input int col, input int img_w);
        return row * img_w + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/window_tap_addr.sv
// ============================================================================
// window_tap_addr : combinational address and in-bounds mask for one tap.
//                   Optional base offset under WINDOW_ADDR_GEN_BASE_EN.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module window_tap_addr
    import conv_addr_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int ADDR_W  = 10,
    parameter int COORD_W = 12
) (
    input  logic signed [COORD_W-1:0] row,
    input  logic signed [COORD_W-1:0] col,
`ifdef WINDOW_ADDR_GEN_BASE_EN
    input  logic        [ADDR_W-1:0]  base,
`endif
    output logic        [ADDR_W-1:0]  addr,
    output logic                      mask
);

    int w_row;
    int w_col;

    assign w_row = int'(row);
    assign w_col = int'(col);

    always_comb begin
        mask = in_bounds(w_row, w_col, IMG_H, IMG_W);
        addr = '0;
        if (mask) begin
`ifdef WINDOW_ADDR_GEN_BASE_EN
            addr = ADDR_W'(pix_addr(w_row, w_col, IMG_W)) + base;
`else
            addr = ADDR_W'(pix_addr(w_row, w_col, IMG_W));
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_addr_gen.sv
// ============================================================================
// window_addr_gen : K x K conv window address generator, row-major output scan
//                   with column reuse. Macro WINDOW_ADDR_GEN_BASE_EN adds base_addr.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module window_addr_gen
    import conv_addr_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int OUT_W  = 28,
    parameter int OUT_H  = 28,
    parameter int K      = 3,
    parameter int STEP   = 1,
    parameter int PAD    = 1,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef WINDOW_ADDR_GEN_BASE_EN
    input  logic [ADDR_W-1:0]     base_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K*ADDR_W-1:0]   out_addr,
    output logic [K-1:0]          out_mask,
    output logic [clog2(K)-1:0]   out_col,
    output logic                  out_newrow,
    output logic                  out_last
);

    localparam int COORD_W = coord_w(ADDR_W);
    localparam int I_W     = clog2(OUT_H);
    localparam int J_W     = clog2(OUT_W);
    localparam int C_W     = clog2(K);

    state_t             r_state;
    logic [I_W-1:0]     r_i;
    logic [J_W-1:0]     r_j;
    logic [C_W-1:0]     r_c;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [K*ADDR_W-1:0] r_addr;
    logic [K-1:0]       r_mask;
    logic               r_newrow;
    logic               r_last;

    state_t             w_nstate;
    logic [I_W-1:0]     w_ni;
    logic [J_W-1:0]     w_nj;
    logic [C_W-1:0]     w_nc;
    logic               w_end;
    logic               w_xfer;
    logic               w_load;
    logic               w_nlast;
    logic [K*ADDR_W-1:0] w_addr;
    logic [K-1:0]       w_mask;
    logic signed [COORD_W-1:0] w_col;

`ifdef WINDOW_ADDR_GEN_BASE_EN
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  w_base;

    // The first beat is computed in IDLE, before r_base has captured the port.
    assign w_base = (r_state == ST_IDLE) ? base_addr : r_base;
`endif

    // Next-beat position; the register stage loads it on start or on handshake.
    always_comb begin
        w_nstate = r_state;
        w_ni     = r_i;
        w_nj     = r_j;
        w_nc     = r_c;
        w_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nstate = ST_FULL;
                w_ni     = '0;
                w_nj     = '0;
                w_nc     = '0;
            end
            ST_FULL: begin
                if (r_c != C_W'(K - 1)) begin
                    w_nc = r_c + C_W'(1);
                end else if (OUT_W == 1) begin
                    if (r_i == I_W'(OUT_H - 1)) begin
                        w_end = 1'b1;
                    end else begin
                        w_ni = r_i + I_W'(1);
                        w_nc = '0;
                    end
                end else begin
                    w_nstate = ST_SLIDE;
                    w_nj     = J_W'(1);
                end
            end
            ST_SLIDE: begin
                if (r_j != J_W'(OUT_W - 1)) begin
                    w_nj = r_j + J_W'(1);
                end else if (r_i == I_W'(OUT_H - 1)) begin
                    w_end = 1'b1;
                end else begin
                    w_nstate = ST_FULL;
                    w_ni     = r_i + I_W'(1);
                    w_nj     = '0;
                    w_nc     = '0;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
            end
        endcase
    end

    assign w_nlast = (w_ni == I_W'(OUT_H - 1)) && (w_nj == J_W'(OUT_W - 1))
                   && (w_nc == C_W'(K - 1));

    assign w_xfer = r_valid && out_ready
                 && ((r_state == ST_FULL) || (r_state == ST_SLIDE));
    assign w_load = ((r_state == ST_IDLE) && start) || (w_xfer && !w_end);

    assign w_col = COORD_W'(STEP * (int'(w_nj) - PAD + int'(w_nc)));

    for (genvar t = 0; t < K; t++) begin : g_tap
        logic signed [COORD_W-1:0] w_row;

        assign w_row = COORD_W'(STEP * (int'(w_ni) - PAD + t));

        window_tap_addr #(
            .IMG_W   (IMG_W),
            .IMG_H   (IMG_H),
            .ADDR_W  (ADDR_W),
            .COORD_W (COORD_W)
        ) u_tap (
            .row  (w_row),
            .col  (w_col),
`ifdef WINDOW_ADDR_GEN_BASE_EN
            .base (w_base),
`endif
            .addr (w_addr[t*ADDR_W +: ADDR_W]),
            .mask (w_mask[t])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_c      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_mask   <= '0;
            r_newrow <= 1'b0;
            r_last   <= 1'b0;
`ifdef WINDOW_ADDR_GEN_BASE_EN
            r_base   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FULL;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
`ifdef WINDOW_ADDR_GEN_BASE_EN
                        r_base  <= base_addr;
`endif
                    end
                end
                ST_FULL, ST_SLIDE: begin
                    if (w_xfer) begin
                        if (w_end) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= w_nstate;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_load) begin
                r_i      <= w_ni;
                r_j      <= w_nj;
                r_c      <= w_nc;
                r_addr   <= w_addr;
                r_mask   <= w_mask;
                r_newrow <= (w_nstate == ST_FULL);
                r_last   <= w_nlast;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign out_valid  = r_valid;
    assign out_addr   = r_addr;
    assign out_mask   = r_mask;
    assign out_col    = r_c;
    assign out_newrow = r_newrow;
    assign out_last   = r_last;

endmodule

`default_nettype wire

// File: tb/tb_window_addr_gen.sv
// ============================================================================
// tb_window_addr_gen : scoreboard bench for window_addr_gen with a frame-level
//                      reference model and random backpressure.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_window_addr_gen;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int OUT_W  = 28;
    localparam int OUT_H  = 28;
    localparam int K      = 3;
    localparam int STEP   = 1;
    localparam int PAD    = 1;
    localparam int ADDR_W = 10;
    localparam int CW     = 2;
    localparam int FRAME_BEATS = OUT_H * (K + OUT_W - 1);

    typedef struct {
        logic [K*ADDR_W-1:0] addr;
        logic [K-1:0]        mask;
        int                  col;
        bit                  newrow;
        bit                  last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic busy, done, out_valid, out_newrow, out_last;
    logic [K*ADDR_W-1:0] out_addr;
    logic [K-1:0] out_mask;
    logic [CW-1:0] out_col;

    logic start2 = 1'b0;
    logic ready2 = 1'b1;
    logic [ADDR_W-1:0] base2 = '0;
    logic busy2, done2, valid2, newrow2, last2;
    logic [K*ADDR_W-1:0] addr2;
    logic [K-1:0] mask2;
    logic [CW-1:0] col2;

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    int done_count = 0;
    int b2 = 0;
    int done2_count = 0;
    bit rand_ready = 1'b0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    window_addr_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
        .K(K), .STEP(STEP), .PAD(PAD), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef WINDOW_ADDR_GEN_BASE_EN
        .base_addr(base_addr),
`endif
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_mask(out_mask), .out_col(out_col),
        .out_newrow(out_newrow), .out_last(out_last)
    );

    window_addr_gen #(
        .IMG_W(28), .IMG_H(28), .OUT_W(14), .OUT_H(14),
        .K(3), .STEP(2), .PAD(1), .ADDR_W(10)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef WINDOW_ADDR_GEN_BASE_EN
        .base_addr(base2),
`endif
        .busy(busy2), .done(done2), .out_valid(valid2), .out_ready(ready2),
        .out_addr(addr2), .out_mask(mask2), .out_col(col2),
        .out_newrow(newrow2), .out_last(last2)
    );

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference: whole frame straight from the scan/reuse rules.
    task automatic build_frame(input int base);
        beat_t e;
        int ncol, c, row, col, a;
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                ncol = (j == 0) ? K : 1;
                for (int b = 0; b < ncol; b++) begin
                    c = (j == 0) ? b : K - 1;
                    e.col    = c;
                    e.newrow = (j == 0);
                    e.last   = (i == OUT_H - 1) && (j == OUT_W - 1) && (b == ncol - 1);
                    e.addr   = '0;
                    e.mask   = '0;
                    for (int t = 0; t < K; t++) begin
                        row = STEP * (i - PAD) + STEP * t;
                        col = STEP * (j - PAD) + STEP * c;
                        if (row >= 0 && row < IMG_H && col >= 0 && col < IMG_W) begin
                            e.mask[t] = 1'b1;
                            a = (row * IMG_W + col + base) % (1 << ADDR_W);
                            e.addr[t*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
                        end
                    end
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial begin
        bit hold;
        logic [K*ADDR_W-1:0] h_addr;
        logic [K-1:0] h_mask;
        logic [CW-1:0] h_col;
        logic h_newrow, h_last;
        beat_t e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("stall_stable",
                          out_valid && out_addr == h_addr && out_mask == h_mask &&
                          out_col == h_col && out_newrow == h_newrow && out_last == h_last,
                          $sformatf("got valid=%b addr=%h mask=%b col=%0d, held addr=%h mask=%b col=%0d",
                                    out_valid, out_addr, out_mask, out_col, h_addr, h_mask, h_col));
                end
                hold = out_valid && !out_ready;
                h_addr = out_addr; h_mask = out_mask; h_col = out_col;
                h_newrow = out_newrow; h_last = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1'b0, $sformatf("beat %0d addr=%h with empty scoreboard",
                                                            beats_seen, out_addr));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat",
                              out_addr == e.addr && out_mask == e.mask && int'(out_col) == e.col &&
                              out_newrow == e.newrow && out_last == e.last && busy,
                              $sformatf("beat %0d got addr=%h mask=%b col=%0d newrow=%b last=%b busy=%b, expected addr=%h mask=%b col=%0d newrow=%b last=%b busy=1",
                                        beats_seen, out_addr, out_mask, out_col, out_newrow, out_last, busy,
                                        e.addr, e.mask, e.col, e.newrow, e.last));
                    end
                    beats_seen++;
                end
                if (done) begin
                    done_count++;
                    check("done_after_last", exp_q.size() == 0 && !out_valid,
                          $sformatf("done with %0d beats pending, valid=%b; expected 0 pending, valid=0",
                                    exp_q.size(), out_valid));
                end
            end
        end
    end

    initial begin
        logic [K*ADDR_W-1:0] x;
        x = {10'd116, 10'd60, 10'd4};
        forever begin
            @(negedge clk);
            if (!rst && done2) done2_count++;
            if (!rst && valid2 && ready2) begin
                if (b2 == 19) begin
                    check("step2_pos11", addr2 == x && mask2 == 3'b111 && col2 == 2'd2 && !newrow2,
                          $sformatf("got addr=%h mask=%b col=%0d newrow=%b, expected addr=%h mask=111 col=2 newrow=0",
                                    addr2, mask2, col2, newrow2, x));
                end
                b2++;
            end
        end
    end

    task automatic run_frame(input bit rr, input bit pulses, input int abort_at, input int base);
        int done0;
        bit got;
        done0 = done_count;
        got = 1'b0;
        rand_ready = rr;
        @(negedge clk);
        exp_q.delete();
`ifdef WINDOW_ADDR_GEN_BASE_EN
        base_addr = base[ADDR_W-1:0];
        build_frame(base);
`else
        build_frame(0);
`endif
        beats_seen = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef WINDOW_ADDR_GEN_BASE_EN
        base_addr = ADDR_W'($urandom);
`endif
        check("start_latency", out_valid && busy,
              $sformatf("got valid=%b busy=%b after start, expected 1 1", out_valid, busy));
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            #3;
            if (abort_at >= 0 && beats_seen >= abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                check("async_reset", !out_valid && !busy && !done,
                      $sformatf("got valid=%b busy=%b done=%b, expected 0 0 0", out_valid, busy, done));
                exp_q.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("no_done_on_abort", done_count == done0 && !out_valid && !busy,
                      $sformatf("got done pulses=%0d valid=%b, expected 0 and 0", done_count - done0, out_valid));
                return;
            end
            if (done_count != done0) begin
                got = 1'b1;
                break;
            end
            start = pulses && busy && ($urandom_range(19, 0) == 0);
        end
        if (!got) begin
            check("frame_timeout", 1'b0, $sformatf("no done after %0d beats", beats_seen));
        end else begin
            start = pulses;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (4) @(negedge clk);
            check("frame_end", !out_valid && !busy && exp_q.size() == 0 &&
                  beats_seen == FRAME_BEATS && done_count == done0 + 1,
                  $sformatf("got valid=%b busy=%b pending=%0d beats=%0d dones=%0d, expected 0 0 0 %0d 1",
                            out_valid, busy, exp_q.size(), beats_seen, done_count - done0, FRAME_BEATS));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", !out_valid && !busy && !done && !out_newrow && !out_last,
              $sformatf("got valid=%b busy=%b done=%b newrow=%b last=%b, expected all 0",
                        out_valid, busy, done, out_newrow, out_last));
        check("reset_data", out_addr == '0 && out_mask == '0 && out_col == '0,
              $sformatf("got addr=%h mask=%b col=%0d, expected 0", out_addr, out_mask, out_col));
        rst = 1'b0;

        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int cyc = 0; cyc < 2000 && done2_count == 0; cyc++) @(negedge clk);
        check("step2_frame", done2_count == 1 && b2 == 14 * 16,
              $sformatf("got dones=%0d beats=%0d, expected 1 and %0d", done2_count, b2, 14 * 16));

        run_frame(1'b0, 1'b0, -1, 784);
        run_frame(1'b1, 1'b1, -1, int'($urandom_range(1023, 0)));
        run_frame(1'b1, 1'b0, 100, int'($urandom_range(1023, 0)));
        run_frame(1'b1, 1'b0, -1, int'($urandom_range(1023, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
